// File: rtl/instr_prefetch_queue.sv
// Instruction fetch front end: PC owner, credit-limited fetch requests,
// and an in-order instruction/address queue feeding decode.
module instr_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int IW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [IW-1:0] mem_rdata,
  output logic          id_valid,
  output logic [IW-1:0] id_instr,
  output logic [AW-1:0] id_pc,
  input  logic          id_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          proto_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] resp_pc;
  logic [IW-1:0] q_instr [DEPTH];
  logic [AW-1:0] q_pc    [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW:0]   inflight;
  logic          grant;
  logic          rsp_live;
  logic          rsp_drop;
  logic          rsp_push;
  logic          pop;

  // Credits cover buffered plus in-flight fetches, so responses never stall.
  assign inflight = {1'b0, count} + {1'b0, outstanding};
  assign mem_req  = !rst && !redirect && (inflight < LIMIT);
  assign mem_addr = fetch_pc;
  assign grant    = mem_req && mem_gnt;

  assign rsp_live = mem_rvalid && (outstanding != '0);
  assign rsp_drop = rsp_live && (discard != '0);
  assign rsp_push = rsp_live && (discard == '0);

  assign id_valid = (count != '0);
  assign id_instr = id_valid ? q_instr[rd_ptr] : '0;
  assign id_pc    = id_valid ? q_pc[rd_ptr] : '0;
  assign pop      = id_valid && id_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= '0;
      resp_pc     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      proto_err   <= 1'b0;
    end else begin
      if (mem_rvalid && (outstanding == '0))
        proto_err <= 1'b1;
      if (redirect) begin
        // Everything still in flight, minus a response landing now, is stale.
        fetch_pc    <= redirect_pc;
        resp_pc     <= redirect_pc;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        count       <= '0;
        outstanding <= outstanding - CW'(rsp_live);
        discard     <= outstanding - CW'(rsp_live);
      end else begin
        if (grant)
          fetch_pc <= fetch_pc + AW'(1);
        if (rsp_push) begin
          resp_pc <= resp_pc + AW'(1);
          wr_ptr  <= wr_ptr + PW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        outstanding <= outstanding + CW'(grant) - CW'(rsp_live);
        discard     <= discard - CW'(rsp_drop);
        count       <= count + CW'(rsp_push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !redirect && rsp_push) begin
      q_instr[wr_ptr] <= mem_rdata;
      q_pc[wr_ptr]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with an in-order
// fixed-latency memory model driving the response port.
module tb_instr_prefetch_queue;

  localparam int AW = 4;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [IW-1:0] mem_rdata = '0;
  logic          id_valid;
  logic [IW-1:0] id_instr;
  logic [AW-1:0] id_pc;
  logic          id_ready = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          proto_err;

  always #5 clk = ~clk;

  instr_prefetch_queue #(.DEPTH(4), .AW(AW), .IW(IW)) dut (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .id_valid(id_valid),
    .id_instr(id_instr),
    .id_pc(id_pc),
    .id_ready(id_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .proto_err(proto_err)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } rsp_t;

  rsp_t          pend[$];
  logic [IW-1:0] img [16];
  int            cyc = 0;
  int            lat = 1;
  int            grants = 0;
  int            total = 0;
  int            bad = 0;

  logic          nx_rst = 1'b1;
  logic          nx_gnt = 1'b0;
  logic          nx_rdy = 1'b0;
  logic          nx_redir = 1'b0;
  logic          nx_spur = 1'b0;
  logic [AW-1:0] nx_rpc = '0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle at the falling edge, then sample 1ns later.
  task automatic tick();
    rsp_t r;
    @(negedge clk);
    cyc++;
    rst         = nx_rst;
    mem_gnt     = nx_gnt;
    id_ready    = nx_rdy;
    redirect    = nx_redir;
    redirect_pc = nx_rpc;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    if (nx_rst) begin
      pend.delete();
    end else if (nx_spur) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 8'hFF;
    end else if (pend.size() > 0 && pend[0].due == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = img[pend[0].addr];
      void'(pend.pop_front());
    end
    #1;
    if (mem_req && mem_gnt) begin
      r.addr = mem_addr;
      r.due  = cyc + lat;
      pend.push_back(r);
      grants++;
    end
  endtask

  task automatic do_reset();
    nx_rst   = 1'b1;
    nx_gnt   = 1'b0;
    nx_rdy   = 1'b0;
    nx_redir = 1'b0;
    nx_spur  = 1'b0;
    tick();
    tick();
    nx_rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      logic [3:0] n;
      n = i[3:0];
      img[i] = {n, ~n};
    end

    // Reset values
    do_reset();
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_valid", id_valid, 0);
    chk("rst_instr", id_instr, 0);
    chk("rst_pc", id_pc, 0);
    chk("rst_err", proto_err, 0);

    // Streaming, L=1
    lat = 1; nx_gnt = 1; nx_rdy = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("s_req", mem_req, 1);
      chk("s_addr", mem_addr, k);
      if (k >= 2) begin
        chk("s_valid", id_valid, 1);
        chk("s_pc", id_pc, k - 2);
        chk("s_instr", id_instr, img[k-2]);
      end else begin
        chk("s_nvalid", id_valid, 0);
      end
    end

    // Backpressure fills the queue
    do_reset();
    lat = 1; nx_gnt = 1; nx_rdy = 0;
    grants = 0;
    for (int k = 0; k < 8; k++) tick();
    chk("bp_grants", grants, 4);
    chk("bp_req", mem_req, 0);
    chk("bp_valid", id_valid, 1);
    chk("bp_pc", id_pc, 0);
    nx_rdy = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_dvalid", id_valid, 1);
      chk("bp_dpc", id_pc, k);
      chk("bp_dinstr", id_instr, img[k]);
      if (k == 0) chk("bp_req0", mem_req, 0);
      if (k == 1) begin
        chk("bp_req1", mem_req, 1);
        chk("bp_addr1", mem_addr, 4);
      end
    end

    // L=3 redirect with three in flight
    do_reset();
    lat = 3; nx_gnt = 1; nx_rdy = 1;
    for (int k = 0; k < 3; k++) tick();
    nx_redir = 1; nx_rpc = 4'hA;
    tick();
    chk("rd_req", mem_req, 0);
    nx_redir = 0;
    tick();
    chk("rd_req1", mem_req, 1);
    chk("rd_addr1", mem_addr, 4'hA);
    chk("rd_v4", id_valid, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rd_stale", id_valid, 0);
    end
    tick();
    chk("rd_valid", id_valid, 1);
    chk("rd_pc", id_pc, 4'hA);
    chk("rd_instr", id_instr, 8'hA5);
    tick();
    chk("rd_pc2", id_pc, 4'hB);
    chk("rd_instr2", id_instr, 8'hB4);

    // PC wrap from 0xE
    do_reset();
    lat = 1; nx_gnt = 1; nx_rdy = 1;
    nx_redir = 1; nx_rpc = 4'hE;
    tick();
    chk("w_req", mem_req, 0);
    nx_redir = 0;
    tick();
    chk("w_addr0", mem_addr, 4'hE);
    tick();
    chk("w_addr1", mem_addr, 4'hF);
    tick();
    chk("w_addr2", mem_addr, 4'h0);
    chk("w_pc0", id_pc, 4'hE);
    chk("w_in0", id_instr, 8'hE1);
    tick();
    chk("w_pc1", id_pc, 4'hF);
    chk("w_in1", id_instr, 8'hF0);
    tick();
    chk("w_pc2", id_pc, 4'h0);
    chk("w_in2", id_instr, 8'h0F);
    tick();
    chk("w_pc3", id_pc, 4'h1);
    chk("w_in3", id_instr, 8'h1E);

    // Redirect with rvalid and pop in the same cycle, count=2
    do_reset();
    lat = 1; nx_gnt = 1; nx_rdy = 0;
    for (int k = 0; k < 3; k++) tick();
    nx_redir = 1; nx_rpc = 4'h5; nx_rdy = 1; nx_gnt = 0;
    tick();
    chk("rc_pre_v", id_valid, 1);
    chk("rc_pre_pc", id_pc, 0);
    nx_redir = 0; nx_rdy = 0; nx_gnt = 1;
    tick();
    chk("rc_empty", id_valid, 0);
    chk("rc_req", mem_req, 1);
    chk("rc_addr", mem_addr, 4'h5);
    chk("rc_err", proto_err, 0);
    nx_gnt = 0;
    tick();
    chk("rc_v5", id_valid, 0);
    tick();
    chk("rc_valid", id_valid, 1);
    chk("rc_pc", id_pc, 4'h5);
    chk("rc_instr", id_instr, 8'h5A);
    chk("rc_err2", proto_err, 0);

    // Spurious response with nothing outstanding
    nx_spur = 1;
    tick();
    nx_spur = 0;
    tick();
    chk("sp_err", proto_err, 1);
    chk("sp_pc", id_pc, 4'h5);
    nx_rdy = 1;
    tick();
    nx_rdy = 0;
    tick();
    chk("sp_nopush", id_valid, 0);
    for (int k = 0; k < 3; k++) tick();
    chk("sp_held", proto_err, 1);
    do_reset();
    chk("sp_clr", proto_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
